unit_a: RTL and testbench
=========================

# unit_a

32-bit two's-complement arithmetic unit performing add, subtract, inverted-A add and increment, selected by a 2-bit function code. It produces a 32-bit result, a carry-out and a signed-overflow flag, all registered on one clock. It serves as the arithmetic slice of the datapath ALU; logic functions live elsewhere.

## Interface
Parameters: none (width fixed at 32).
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- A  input  32  operand A
- B  input  32  operand B
- f  input  2  function select: 00 add, 01 sub, 10 ainv, 11 inc
- S  output  32  registered result
- c_out  output  1  registered carry out of bit 31
- O  output  1  registered signed-overflow flag
- Z  output  1  registered zero flag; present only with UNIT_A_ZERO_FLAG_EN

## Operation
- All functions map onto one 32-bit adder, S = X + Y + cin:
  - f=00 add: X=A, Y=B, cin=0 (A+B)
  - f=01 sub: X=A, Y=~B, cin=1 (A−B)
  - f=10 ainv: X=~A, Y=B, cin=0 (B−A−1)
  - f=11 inc: X=A, Y=0, cin=1 (A+1); B ignored
- c_out = carry out of bit 31 of that addition. For sub, c_out=1 means no borrow (A ≥ B unsigned).
- O = (X[31] == Y[31]) && (S[31] != X[31]), computed from the adder operands actually used, not raw A/B.
- Results wrap modulo 2^32; no saturation.
- Z (when enabled) = (S == 0), from the same result being registered.

## Timing
- Fully pipelined, latency 1: inputs present before rising edge N appear on S/c_out/O at edge N. A new operation is accepted every cycle.
- No handshake or enable; outputs reload every cycle.
- Reset: while rst=1 at a rising edge, S=32'h0, c_out=0, O=0, Z=0 (if present). Reset overrides any operation in the same cycle. The first valid result appears one edge after rst deasserts.
- Outputs hold their value only through the clock period; there is no combinational path from inputs to outputs.

## Configuration
- UNIT_A_ZERO_FLAG_EN:
  - Defined: port Z exists and is registered with the other outputs; reset value 0.
  - Undefined: Z port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package unit_a_pkg:
  - Function-code constants UNIT_A_F_ADD=2'b00, UNIT_A_F_SUB=2'b01, UNIT_A_F_AINV=2'b10, UNIT_A_F_INC=2'b11
  - Data-width constant 32
- Sub-module unit_a_adder32: combinational 32-bit adder (X, Y, cin → sum, cout, ovf), built as a ripple or carry-lookahead chain.
- Top level: operand muxing, output registers and reset.

## Test plan
- Reset: rst=1 for 2 cycles with A=B=32'hFFFFFFFF, f=00 → S=0, c_out=0, O=0 at each edge.
- A=6, B=6:
  - f=00 → S=12, c_out=0, O=0
  - f=01 → S=0, c_out=1, O=0
- A=0, B=6:
  - f=10 → S=5, c_out=1, O=0
  - f=11 → S=1, c_out=0, O=0
- Overflow, A=32'h7FFFFFFF:
  - B=1, f=00 → S=32'h80000000, O=1
  - B=1, f=01 → S=32'h7FFFFFFE, O=0, c_out=1
  - B=32'hFFFFFFFF, f=01 → S=32'h80000000, O=1, c_out=0
  - B=32'h80000000, f=10 → S=0, c_out=1, O=1
- Wrap and back-to-back: A=32'hFFFFFFFF, f=11 → S=0, c_out=1, O=0 (Z=1 with UNIT_A_ZERO_FLAG_EN). Change the operation every cycle and check each result appears exactly one edge later.
- Reset mid-stream: assert rst during a sequence of adds → outputs 0 at that edge; results resume one edge after release.

Source files
------------

// File: rtl/unit_a_pkg.sv
// unit_a shared constants and operand helper.
// Function codes, datapath width, adder operand bundle.
package unit_a_pkg;

    localparam int UNIT_A_W = 32;

    localparam logic [1:0] UNIT_A_F_ADD  = 2'b00;
    localparam logic [1:0] UNIT_A_F_SUB  = 2'b01;
    localparam logic [1:0] UNIT_A_F_AINV = 2'b10;
    localparam logic [1:0] UNIT_A_F_INC  = 2'b11;

    typedef struct packed {
        logic [UNIT_A_W-1:0] x;
        logic [UNIT_A_W-1:0] y;
        logic                cin;
    } unit_a_opnd_t;

    // Map a function code onto the single adder's X, Y and carry-in.
    function automatic unit_a_opnd_t unit_a_operands(
        input logic [UNIT_A_W-1:0] a,
        input logic [UNIT_A_W-1:0] b,
        input logic [1:0]          f
    );
        unit_a_opnd_t o;
        o = '{x: a, y: b, cin: 1'b0};
        unique case (f)
            UNIT_A_F_ADD:  o = '{x: a,  y: b,  cin: 1'b0};
            UNIT_A_F_SUB:  o = '{x: a,  y: ~b, cin: 1'b1};
            UNIT_A_F_AINV: o = '{x: ~a, y: b,  cin: 1'b0};
            UNIT_A_F_INC:  o = '{x: a,  y: '0, cin: 1'b1};
            default:       o = '{x: a,  y: b,  cin: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/unit_a_adder32.sv
// unit_a_adder32: combinational 32-bit adder.
// Produces sum, carry out of bit 31 and signed overflow.
module unit_a_adder32
    import unit_a_pkg::*;
(
    input  logic [UNIT_A_W-1:0] x,
    input  logic [UNIT_A_W-1:0] y,
    input  logic                cin,
    output logic [UNIT_A_W-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    logic [UNIT_A_W:0] full;

    // One extra bit captures the carry out of the top bit.
    always_comb begin
        full = {1'b0, x} + {1'b0, y} + {{UNIT_A_W{1'b0}}, cin};
        sum  = full[UNIT_A_W-1:0];
        cout = full[UNIT_A_W];
        ovf  = (x[UNIT_A_W-1] == y[UNIT_A_W-1]) &&
               (sum[UNIT_A_W-1] != x[UNIT_A_W-1]);
    end

endmodule

// File: rtl/unit_a.sv
// unit_a: registered 32-bit add/sub/ainv/inc slice.
// Optional zero flag Z enabled by UNIT_A_ZERO_FLAG_EN.
module unit_a
    import unit_a_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [UNIT_A_W-1:0] A,
    input  logic [UNIT_A_W-1:0] B,
    input  logic [1:0]          f,
    output logic [UNIT_A_W-1:0] S,
    output logic                c_out,
`ifdef UNIT_A_ZERO_FLAG_EN
    output logic                Z,
`endif
    output logic                O
);

    unit_a_opnd_t        op;
    logic [UNIT_A_W-1:0] sum;
    logic                cout;
    logic                ovf;

    // Select adder operands from the function code.
    always_comb begin
        op = unit_a_operands(A, B, f);
    end

    unit_a_adder32 u_add (
        .x    (op.x),
        .y    (op.y),
        .cin  (op.cin),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    // Register result and flags; reset wins over any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            S     <= '0;
            c_out <= 1'b0;
            O     <= 1'b0;
        end else begin
            S     <= sum;
            c_out <= cout;
            O     <= ovf;
        end
    end

`ifdef UNIT_A_ZERO_FLAG_EN
    // Zero flag taken from the same sum being registered.
    always_ff @(posedge clk) begin
        if (rst) Z <= 1'b0;
        else     Z <= (sum == '0);
    end
`endif

endmodule

// File: tb/tb_unit_a.sv
// tb_unit_a: randomized check of unit_a against an arithmetic model.
// Also pins hand-computed results from the test plan.
module tb_unit_a;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic [1:0]  f_in;
    logic [31:0] s;
    logic        c, o;
    logic        z;
    bit          active = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    always #5 clk = ~clk;

`ifndef UNIT_A_ZERO_FLAG_EN
    assign z = 1'b0;
`endif

    unit_a dut (
        .clk   (clk),
        .rst   (rst),
        .A     (a_in),
        .B     (b_in),
        .f     (f_in),
        .S     (s),
        .c_out (c),
`ifdef UNIT_A_ZERO_FLAG_EN
        .Z     (z),
`endif
        .O     (o)
    );

    function automatic bit out_of_range(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Arithmetic meaning of each function, from plain integer math.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] f, input logic r);
        exp_t e;
        longint ua, ub, sa, sb, res;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e = '{s: 32'h0, c: 1'b0, o: 1'b0, z: 1'b0};
        if (r) return e;
        case (f)
            2'b00: begin
                res = ua + ub;
                e.c = (res >= 64'sh1_0000_0000);
                e.o = out_of_range(sa + sb);
            end
            2'b01: begin
                res = ua - ub;
                e.c = (ua >= ub);
                e.o = out_of_range(sa - sb);
            end
            2'b10: begin
                res = ub - ua - 1;
                e.c = (ub > ua);
                e.o = out_of_range(sb - sa - 1);
            end
            default: begin
                res = ua + 1;
                e.c = (a == 32'hFFFF_FFFF);
                e.o = (a == 32'h7FFF_FFFF);
            end
        endcase
        e.s = res[31:0];
        e.z = (e.s == 32'h0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] es,
                       input logic ec, input logic eo, input logic ez);
        bit bad;
        vectors++;
        bad = (s !== es) || (c !== ec) || (o !== eo);
`ifdef UNIT_A_ZERO_FLAG_EN
        bad = bad || (z !== ez);
`endif
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got S=%h c=%b O=%b Z=%b, want S=%h c=%b O=%b Z=%b",
                     name, s, c, o, z, es, ec, eo, ez);
        end
    endtask

    // Every edge: model the sampled inputs, compare one step later.
    always @(posedge clk) begin
        exp_t e;
        if (active) begin
            e = model(a_in, b_in, f_in, rst);
            #1;
            chk("stream", e.s, e.c, e.o, e.z);
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] f, input logic r);
        @(negedge clk);
        a_in = a;
        b_in = b;
        f_in = f;
        rst  = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst  = 1'b1;
        a_in = 32'hFFFF_FFFF;
        b_in = 32'hFFFF_FFFF;
        f_in = 2'b00;
        @(posedge clk);
        #2;
        active = 1'b1;
        chk("reset0", 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1);
        chk("reset1", 32'h0, 1'b0, 1'b0, 1'b0);

        step(32'd6, 32'd6, 2'b00, 1'b0);
        chk("add6", 32'd12, 1'b0, 1'b0, 1'b0);
        step(32'd6, 32'd6, 2'b01, 1'b0);
        chk("sub6", 32'd0, 1'b1, 1'b0, 1'b1);
        step(32'd0, 32'd6, 2'b10, 1'b0);
        chk("ainv", 32'd5, 1'b1, 1'b0, 1'b0);
        step(32'd0, 32'd6, 2'b11, 1'b0);
        chk("inc0", 32'd1, 1'b0, 1'b0, 1'b0);
        step(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0);
        chk("addovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 32'd1, 2'b01, 1'b0);
        chk("subnov", 32'h7FFF_FFFE, 1'b1, 1'b0, 1'b0);
        step(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0);
        chk("subovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step(32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 1'b0);
        chk("ainvovf", 32'h0, 1'b1, 1'b1, 1'b1);
        step(32'hFFFF_FFFF, 32'h1234_5678, 2'b11, 1'b0);
        chk("incwrap", 32'h0, 1'b1, 1'b0, 1'b1);
        step(32'h7FFF_FFFF, 32'h0, 2'b11, 1'b0);
        chk("incovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        step(32'd10, 32'd20, 2'b00, 1'b0);
        chk("mid_add", 32'd30, 1'b0, 1'b0, 1'b0);
        step(32'd10, 32'd20, 2'b00, 1'b1);
        chk("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        step(32'd3, 32'd4, 2'b00, 1'b0);
        chk("resume", 32'd7, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h7FFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                3: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            step(ra, rb, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 31) == 0));
        end

        @(negedge clk);
        active = 1'b0;
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
